// File: rtl/clock_ui_pkg.sv
// Shared front-panel types: one-hot cursor encoding and repeat FSM states.
// Used by the button controller, ClockStateStorage and the display driver.
package clock_ui_pkg;

  localparam int CURSOR_W = 3;

  localparam logic [CURSOR_W-1:0] CURSOR_SEC  = 3'b001;
  localparam logic [CURSOR_W-1:0] CURSOR_MIN  = 3'b010;
  localparam logic [CURSOR_W-1:0] CURSOR_HOUR = 3'b100;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HELD,
    RPT_REPEAT
  } rpt_state_t;

  // sec -> min -> hour -> sec
  function automatic logic [CURSOR_W-1:0] cursor_left(
    input logic [CURSOR_W-1:0] c
  );
    return {c[CURSOR_W-2:0], c[CURSOR_W-1]};
  endfunction

  // sec -> hour -> min -> sec
  function automatic logic [CURSOR_W-1:0] cursor_right(
    input logic [CURSOR_W-1:0] c
  );
    return {c[0], c[CURSOR_W-1:1]};
  endfunction

endpackage

// File: rtl/clock_button_controller_debouncer.sv
// Per-button 2-flop synchronizer, stability counter and press pulse.
// Pulse is registered one cycle after the debounced level rises.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pressPulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          levelD;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      level      <= 1'b0;
      levelD     <= 1'b0;
      pressPulse <= 1'b0;
      cnt        <= '0;
    end else begin
      s1         <= raw;
      s2         <= s1;
      levelD     <= level;
      pressPulse <= level & ~levelD;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_button_controller.sv
// Button front end: debounce, up/down/reset pulses, one-hot edit cursor.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the up/down buttons.
module clock_button_controller
  import clock_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btnUp,
  input  logic                btnDown,
  input  logic                btnLeft,
  input  logic                btnRight,
  input  logic                btnReset,
  output logic                up,
  output logic                down,
  output logic                timeReset,
  output logic [CURSOR_W-1:0] cursorPos
);

  logic [4:0] raws;
  logic [4:0] lvls;
  logic [4:0] pps;

  assign raws = {btnReset, btnRight, btnLeft, btnDown, btnUp};

  for (genvar g = 0; g < 5; g++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .raw       (raws[g]),
      .level     (lvls[g]),
      .pressPulse(pps[g])
    );
  end

  logic pUp;
  logic pDown;
  logic pLeft;
  logic pRight;
  logic pRst;

  assign {pRst, pRight, pLeft, pDown, pUp} = pps;

  assign timeReset = pRst;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [1:0]    lv;
  logic [1:0]    pp;
  rpt_state_t    st     [2];
  rpt_state_t    stN    [2];
  logic [RW-1:0] rcnt   [2];
  logic [RW-1:0] rcntN  [2];
  logic [1:0]    rpt;
  logic [1:0]    rptN;

  assign lv = lvls[1:0];
  assign pp = pps[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt <= '0;
      for (int i = 0; i < 2; i++) begin
        st[i]   <= RPT_IDLE;
        rcnt[i] <= '0;
      end
    end else begin
      rpt <= rptN;
      for (int i = 0; i < 2; i++) begin
        st[i]   <= stN[i];
        rcnt[i] <= rcntN[i];
      end
    end
  end

  // The press-pulse cycle counts as the first cycle of the delay.
  always_comb begin
    rptN = '0;
    for (int i = 0; i < 2; i++) begin
      stN[i]   = st[i];
      rcntN[i] = rcnt[i];
      unique case (st[i])
        RPT_IDLE: begin
          if (pp[i]) begin
            stN[i]   = RPT_HELD;
            rcntN[i] = RW'(1);
          end
        end
        RPT_HELD: begin
          if (!lv[i]) begin
            stN[i] = RPT_IDLE;
          end else if (rcnt[i] == DLY_LAST) begin
            stN[i]   = RPT_REPEAT;
            rcntN[i] = '0;
            rptN[i]  = ~lv[1-i];
          end else begin
            rcntN[i] = rcnt[i] + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (!lv[i]) begin
            stN[i] = RPT_IDLE;
          end else if (rcnt[i] == PER_LAST) begin
            rcntN[i] = '0;
            rptN[i]  = ~lv[1-i];
          end else begin
            rcntN[i] = rcnt[i] + 1'b1;
          end
        end
        default: begin
          stN[i] = RPT_IDLE;
        end
      endcase
    end
  end

  assign up   = (pUp & ~pDown) | rpt[0];
  assign down = (pDown & ~pUp) | rpt[1];
`else
  assign up   = pUp & ~pDown;
  assign down = pDown & ~pUp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cursorPos <= CURSOR_SEC;
    end else begin
      unique case (1'b1)
        pRst:            cursorPos <= CURSOR_SEC;
        pLeft & ~pRight: cursorPos <= cursor_left(cursorPos);
        pRight & ~pLeft: cursorPos <= cursor_right(cursorPos);
        default:         cursorPos <= cursorPos;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_button_controller.sv
// Directed bench for clock_button_controller with short debounce/repeat.
// Table of press patterns plus hand sequences for exact timing cases.
module tb_clock_button_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnUp, btnDown, btnLeft, btnRight, btnReset;
  logic       up, down, timeReset;
  logic [2:0] cursorPos;

  int checks = 0;
  int failures = 0;
  int nUp, nDown, nRst;

  always #5 clk = ~clk;

  clock_button_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btnUp    (btnUp),
    .btnDown  (btnDown),
    .btnLeft  (btnLeft),
    .btnRight (btnRight),
    .btnReset (btnReset),
    .up       (up),
    .down     (down),
    .timeReset(timeReset),
    .cursorPos(cursorPos)
  );

  // bit order: {reset, right, left, down, up}
  localparam logic [4:0] B_UP = 5'b00001;
  localparam logic [4:0] B_DN = 5'b00010;
  localparam logic [4:0] B_LT = 5'b00100;
  localparam logic [4:0] B_RT = 5'b01000;
  localparam logic [4:0] B_RS = 5'b10000;

  typedef struct {
    logic [4:0] btn;
    int         hold;
    logic [2:0] cur;
    int         eUp;
    int         eDown;
    int         eRst;
  } vec_t;

  vec_t tbl[10];

  task automatic apply(input logic [4:0] b);
    {btnReset, btnRight, btnLeft, btnDown, btnUp} = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    nUp   += int'(up);
    nDown += int'(down);
    nRst  += int'(timeReset);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    nUp = 0;
    nDown = 0;
    nRst = 0;
  endtask

  task automatic press(input logic [4:0] b, input int hold);
    apply(b);
    repeat (hold) step();
    apply(5'b0);
    repeat (16) step();
  endtask

  int  upRpt;
  logic seen [0:47];
  logic [2:0] curs [0:47];

  initial begin
`ifdef AUTO_REPEAT_EN
    upRpt = 3;
`else
    upRpt = 1;
`endif
    tbl[0] = '{B_LT,        8, 3'b010, 0, 0, 0};
    tbl[1] = '{B_LT,        8, 3'b100, 0, 0, 0};
    tbl[2] = '{B_LT,        8, 3'b001, 0, 0, 0};
    tbl[3] = '{B_RT,        8, 3'b100, 0, 0, 0};
    tbl[4] = '{B_LT | B_RT, 8, 3'b100, 0, 0, 0};
    tbl[5] = '{B_RS,        8, 3'b001, 0, 0, 1};
    tbl[6] = '{B_UP,       30, 3'b001, upRpt, 0, 0};
    tbl[7] = '{B_DN,        3, 3'b001, 0, 0, 0};
    tbl[8] = '{B_UP | B_DN,10, 3'b001, 0, 0, 0};
    tbl[9] = '{B_DN,        8, 3'b001, 0, 1, 0};

    rst = 1'b1;
    apply(5'b0);
    clr();
    repeat (3) step();
    check("rst_up", int'(up), 0);
    check("rst_down", int'(down), 0);
    check("rst_timeReset", int'(timeReset), 0);
    check("rst_cursor", int'(cursorPos), 1);
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 10; i++) begin
      clr();
      press(tbl[i].btn, tbl[i].hold);
      check($sformatf("row%0d_up", i), nUp, tbl[i].eUp);
      check($sformatf("row%0d_down", i), nDown, tbl[i].eDown);
      check($sformatf("row%0d_rst", i), nRst, tbl[i].eRst);
      check($sformatf("row%0d_cursor", i), int'(cursorPos),
            int'(tbl[i].cur));
    end

    // exact up latency (and repeat spacing when enabled)
    clr();
    apply(B_UP);
    for (int i = 0; i < 48; i++) begin
      step();
      seen[i] = up;
      if (i == 29) apply(5'b0);
    end
    check("up_k5", int'(seen[5]), 0);
    check("up_k6", int'(seen[6]), 1);
    check("up_k7", int'(seen[7]), 0);
    check("up_total", nUp, upRpt);
`ifdef AUTO_REPEAT_EN
    check("up_k26", int'(seen[26]), 1);
    check("up_k34", int'(seen[34]), 1);
`endif

    // reset button from hour cursor
    press(B_LT, 8);
    press(B_LT, 8);
    check("pre_rst_cursor", int'(cursorPos), 4);
    clr();
    apply(B_RS);
    for (int i = 0; i < 16; i++) begin
      step();
      seen[i] = timeReset;
      curs[i] = cursorPos;
      if (i == 7) apply(5'b0);
    end
    check("tr_k6", int'(seen[6]), 1);
    check("tr_total", nRst, 1);
    check("tr_cur_k6", int'(curs[6]), 4);
    check("tr_cur_k7", int'(curs[7]), 1);

    // rst during a left debounce, left kept held after rst
    press(B_LT, 8);
    check("pre_mid_cursor", int'(cursorPos), 2);
    apply(B_LT);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    check("mid_rst_cursor", int'(cursorPos), 1);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      curs[i] = cursorPos;
    end
    check("mid_cur_k3", int'(curs[3]), 1);
    check("mid_cur_k6", int'(curs[6]), 1);
    check("mid_cur_k7", int'(curs[7]), 2);
    check("mid_cur_k11", int'(curs[11]), 2);
    apply(5'b0);
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
